// File: rtl/posit_pio_sequencer.sv
// posit_pio_sequencer
//   Runs one posit operation at a time between the HPS-side PIO registers and
//   the posit arithmetic datapath. A rising edge on pio_ctrl[0] captures the
//   operands and opcode. They are handed to the datapath with a valid/ready
//   handshake, and the sequencer then waits for the result under a timeout.
//   The result and a sticky status word are held for the HPS to read back.
//
// Ports
//   clock, reset   fabric clock; asynchronous active-high reset
//   pio_num1/2     operands from the HPS PIOs
//   pio_ctrl       [0]=start level, [1]=clear status, [OPW+1:2]=opcode
//   pio_result     latched result of the last completed operation
//   pio_status     [0]=busy [1]=done [2]=timeout [3]=dropped_start
//                  [CNTW+3:4]=completed-operation count
//   dp_in_*        operand handshake to the datapath (dp_num1/2, dp_op)
//   dp_out_*       result handshake from the datapath (dp_result)
//   dp_flush       one-cycle pulse that aborts the datapath after a timeout
module posit_pio_sequencer #(
  parameter int NBITS   = 32,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NBITS-1:0]  pio_num1,
  input  logic [NBITS-1:0]  pio_num2,
  input  logic [OPW+1:0]    pio_ctrl,
  output logic [NBITS-1:0]  pio_result,
  output logic [CNTW+3:0]   pio_status,
  output logic              dp_in_valid,
  input  logic              dp_in_ready,
  output logic [NBITS-1:0]  dp_num1,
  output logic [NBITS-1:0]  dp_num2,
  output logic [OPW-1:0]    dp_op,
  input  logic              dp_out_valid,
  output logic              dp_out_ready,
  input  logic [NBITS-1:0]  dp_result,
  output logic              dp_flush
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_reg,   state_next;
  logic              start_q_reg, start_q_next;
  logic [NBITS-1:0]  num1_reg,    num1_next;
  logic [NBITS-1:0]  num2_reg,    num2_next;
  logic [OPW-1:0]    op_reg,      op_next;
  logic [NBITS-1:0]  result_reg,  result_next;
  logic [CNTW-1:0]   count_reg,   count_next;
  logic              busy_reg,    busy_next;
  logic              done_reg,    done_next;
  logic              timeout_reg, timeout_next;
  logic              dropped_reg, dropped_next;
  logic              flush_reg,   flush_next;
  logic [TW-1:0]     timer_reg,   timer_next;

  logic start_rise;
  logic clear_req;
  logic expired;

  assign start_rise = pio_ctrl[0] & ~start_q_reg;
  assign clear_req  = pio_ctrl[1];
  assign expired    = (timer_reg == TIMER_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      start_q_reg <= 1'b0;
      num1_reg    <= '0;
      num2_reg    <= '0;
      op_reg      <= '0;
      result_reg  <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      dropped_reg <= 1'b0;
      flush_reg   <= 1'b0;
      timer_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      start_q_reg <= start_q_next;
      num1_reg    <= num1_next;
      num2_reg    <= num2_next;
      op_reg      <= op_next;
      result_reg  <= result_next;
      count_reg   <= count_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      dropped_reg <= dropped_next;
      flush_reg   <= flush_next;
      timer_reg   <= timer_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    start_q_next = pio_ctrl[0];
    num1_next    = num1_reg;
    num2_next    = num2_reg;
    op_next      = op_reg;
    result_next  = result_reg;
    count_next   = count_reg;
    busy_next    = busy_reg;
    done_next    = done_reg;
    timeout_next = timeout_reg;
    dropped_next = dropped_reg;
    flush_next   = 1'b0;
    timer_next   = timer_reg;

    // Clear is applied first so that any event in the same cycle
    // (completion, timeout, dropped start) overrides it.
    if (clear_req) begin
      done_next    = 1'b0;
      timeout_next = 1'b0;
      dropped_next = 1'b0;
      count_next   = '0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start_rise) begin
          num1_next    = pio_num1;
          num2_next    = pio_num2;
          op_next      = pio_ctrl[OPW+1:2];
          done_next    = 1'b0;
          timeout_next = 1'b0;
          busy_next    = 1'b1;
          timer_next   = '0;
          state_next   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (start_rise) dropped_next = 1'b1;
        timer_next = timer_reg + TW'(1);
        // An accepted transfer beats an expiring timer in the same cycle.
        if (dp_in_ready) begin
          timer_next = '0;
          state_next = ST_WAIT;
        end else if (expired) begin
          timeout_next = 1'b1;
          busy_next    = 1'b0;
          flush_next   = 1'b1;
          timer_next   = '0;
          state_next   = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (start_rise) dropped_next = 1'b1;
        timer_next = timer_reg + TW'(1);
        if (dp_out_valid) begin
          result_next = dp_result;
          // Counts from zero if a clear lands on the completion cycle.
          count_next  = (clear_req ? '0 : count_reg) + CNTW'(1);
          done_next   = 1'b1;
          busy_next   = 1'b0;
          timer_next  = '0;
          state_next  = ST_IDLE;
        end else if (expired) begin
          timeout_next = 1'b1;
          busy_next    = 1'b0;
          flush_next   = 1'b1;
          timer_next   = '0;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Valid and ready come straight from the state, so they can never be
  // high together and both are low in IDLE.
  assign dp_in_valid  = (state_reg == ST_ISSUE);
  assign dp_out_ready = (state_reg == ST_WAIT);
  assign dp_num1      = num1_reg;
  assign dp_num2      = num2_reg;
  assign dp_op        = op_reg;
  assign dp_flush     = flush_reg;
  assign pio_result   = result_reg;
  assign pio_status   = {count_reg, dropped_reg, timeout_reg, done_reg, busy_reg};

endmodule
